// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fulladder.sv
// 1-bit full-adder cell used as the bit-serial datapath.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit per clock, LSB first.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | adding one bit per cycle, WIDTH cycles
// DONE  | result published, done pulse; start here chains straight into SHIFT
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, s_q, s_next;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fa_sum, fa_cout;
   logic             accept, last_bit;

   assign accept   = start && (state_q == IDLE || state_q == DONE);
   assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
   assign s_next   = {fa_sum, s_q[WIDTH-1:1]};

   fulladder u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
      done = (state_q == DONE);
   end

   // Outputs only move on the completion edge so they never show partial sums.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         s_q     <= '0;
         carry_q <= cin;
         cnt_q   <= '0;
      end else if (state_q == SHIFT) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         s_q     <= s_next;
         carry_q <= fa_cout;
         cnt_q   <= cnt_q + CNT_W'(1);
         if (last_bit) begin
            sum  <= s_next;
            cout <= fa_cout;
         end
      end
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled on clk rise.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while bits are being processed.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking a new valid result.
REQ-010 SHALL have port: sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  registered carry-out of the full addition.

Function
REQ-012 SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance, load a and b into right-shift registers, carry flop <= cin, bit counter <= 0, next state SHIFT.
REQ-014 SHALL ignore start while in SHIFT; operand registers, counter and carry are unaffected.
REQ-015 SHALL, in each SHIFT cycle, apply LSBs of the A and B shift registers plus the carry flop to one 1-bit full-adder cell: sum bit into MSB of the internal sum shift register, cell carry into the carry flop, A/B shifted right one place, counter +1.
REQ-016 SHALL process bit 0 first and bit WIDTH-1 last, spending exactly WIDTH cycles in SHIFT.
REQ-017 SHALL, on the edge completing bit WIDTH-1, copy the internal sum register to sum and the carry to cout, then enter DONE.
REQ-018 SHALL assert done for exactly the one cycle spent in DONE; DONE returns to IDLE, or to SHIFT if start is sampled high in DONE (back-to-back, no idle cycle).
REQ-019 SHALL drive busy = 1 exactly while state is SHIFT.
REQ-020 SHALL give latency: start sampled at edge N gives done high during the cycle after edge N+WIDTH.
REQ-021 SHALL hold sum and cout stable outside the completion edge; they change only at completion, never mid-operation.
REQ-022 SHALL return cout = 1 whenever a+b+cin >= 2^WIDTH (e.g. all-ones + all-ones + 1 gives sum all-ones, cout 1).

Reset
REQ-023 SHALL, on rst high, immediately force state IDLE, busy 0, done 0, sum 0, cout 0, counter 0, carry 0, and clear operand registers, independent of clk.
REQ-024 SHALL abort any operation when rst is asserted mid-SHIFT, with no done pulse and sum/cout reading 0 afterwards.
REQ-025 SHALL accept start on the first clk rise after rst deasserts.

Structure
REQ-026 SHALL take from shared package adder_pkg: FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default width constant 8.
REQ-027 SHALL size the counter as $clog2(WIDTH+1) bits, declared locally.
REQ-028 SHALL instantiate the team's 1-bit full-adder cell, fulladder (A, B, Cin -> Sum, Cout), once as the bit-serial datapath; all other logic stays in serial_adder.

Verification (WIDTH=8)
REQ-029 SHALL test: a=8'h5A, b=8'h3C, cin=0, start 1 cycle -> busy 8 cycles, done 1 cycle later, sum=8'h96, cout=0.
REQ-030 SHALL test: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-031 SHALL test: start pulsed with a=8'h11, b=8'h22 in the 3rd SHIFT cycle of 8'h0F+8'h01 -> ignored, result sum=8'h10, cout=0, single done pulse.
REQ-032 SHALL test: start held high in DONE with a=8'h80, b=8'h80 -> busy rises the next cycle with no IDLE, second result sum=8'h00, cout=1.
REQ-033 SHALL test: rst asserted mid-SHIFT between clk edges -> outputs zero immediately, no done pulse; next start of 8'h01+8'h01 gives sum=8'h02.
REQ-034 SHALL test: random a, b, cin, 1000 transactions -> {cout,sum} equals a+b+cin, done count equals accepted-start count.
